// File: rtl/key_debounce_pkg.sv
// Shared definitions for push-button debounce blocks: FSM state encoding and
// the default filter count (20 ms at 50 MHz).
package key_debounce_pkg;

  typedef logic [1:0] key_state_t;

  localparam key_state_t ST_IDLE       = 2'd0;
  localparam key_state_t ST_PRESS_FILT = 2'd1;
  localparam key_state_t ST_DOWN       = 2'd2;
  localparam key_state_t ST_REL_FILT   = 2'd3;

  localparam int KEY_CNT_MAX_DEFAULT = 999_999;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: input synchronizer, saturating filter counter and
// press/release FSM. press_o is a combinational one-cycle event.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int CNT_MAX     = KEY_CNT_MAX_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press_o
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  key_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   key_s;
  logic                   press;

  // Synchronizer resets to all ones so a held key looks released after reset.
  assign sync_d = (sync_q << 1) | SYNC_STAGES'(key_in);
  assign key_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!key_s) begin
          state_d = ST_PRESS_FILT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_FILT: begin
        if (key_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TOP) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DOWN: begin
        if (key_s) begin
          state_d = ST_REL_FILT;
          cnt_d   = '0;
        end
      end
      ST_REL_FILT: begin
        if (!key_s) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TOP) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press;

endmodule

// File: rtl/key_debounce.sv
// Two-key debouncer (write/read) with arbitration so the registered press
// pulses never overlap; a colliding event is deferred by one clock.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int CNT_MAX     = KEY_CNT_MAX_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in_wr,
  input  logic key_in_rd,
  output logic key_wr,
  output logic key_rd
);

  logic wr_ev, rd_ev;
  logic wr_pend_q, wr_pend_d;
  logic rd_pend_q, rd_pend_d;
  logic key_wr_q, key_wr_d;
  logic key_rd_q, key_rd_d;

  key_debounce_ch #(.CNT_MAX(CNT_MAX), .SYNC_STAGES(SYNC_STAGES)) u_ch_wr (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in_wr),
    .press_o(wr_ev)
  );

  key_debounce_ch #(.CNT_MAX(CNT_MAX), .SYNC_STAGES(SYNC_STAGES)) u_ch_rd (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in_rd),
    .press_o(rd_ev)
  );

  // A pending rd always drains first; otherwise wr has priority over a fresh rd.
  always_comb begin
    key_wr_d  = 1'b0;
    key_rd_d  = 1'b0;
    wr_pend_d = 1'b0;
    rd_pend_d = 1'b0;
    if (rd_pend_q) begin
      key_rd_d  = 1'b1;
      wr_pend_d = wr_ev | wr_pend_q;
      rd_pend_d = rd_ev;
    end else if (wr_pend_q || wr_ev) begin
      key_wr_d  = 1'b1;
      wr_pend_d = wr_pend_q & wr_ev;
      rd_pend_d = rd_ev;
    end else if (rd_ev) begin
      key_rd_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      key_wr_q  <= 1'b0;
      key_rd_q  <= 1'b0;
    end else begin
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      key_wr_q  <= key_wr_d;
      key_rd_q  <= key_rd_d;
    end
  end

  assign key_wr = key_wr_q;
  assign key_rd = key_rd_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX = 9, SYNC_STAGES = 2.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in_wr = 1'b1;
  logic key_in_rd = 1'b1;
  logic key_wr, key_rd;

  int tests_run = 0;
  int tests_failed = 0;

  int wr_pulses = 0, rd_pulses = 0;
  int wr_hi = 0, rd_hi = 0;
  int both_hi = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0;

  key_debounce #(.CNT_MAX(9), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in_wr(key_in_wr),
    .key_in_rd(key_in_rd),
    .key_wr   (key_wr),
    .key_rd   (key_rd)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (key_wr && !wr_prev) wr_pulses++;
    if (key_rd && !rd_prev) rd_pulses++;
    if (key_wr) wr_hi++;
    if (key_rd) rd_hi++;
    if (key_wr && key_rd) both_hi++;
    wr_prev = key_wr;
    rd_prev = key_rd;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int wr0, rd0;
    rst_n = 1'b0;
    key_in_wr = 1'b1;
    key_in_rd = 1'b1;
    step(3);
    tests_run++;
    if (key_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_key_wr: got %b expected 0", key_wr);
    end
    tests_run++;
    if (key_rd !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_key_rd: got %b expected 0", key_rd);
    end
    rst_n = 1'b1;
    wr0 = wr_pulses;
    rd0 = rd_pulses;
    step(20);
    tests_run++;
    if ((wr_pulses - wr0) !== 0 || (rd_pulses - rd0) !== 0) begin
      tests_failed++;
      $display("FAIL idle_quiet: got wr=%0d rd=%0d expected 0 0", wr_pulses - wr0, rd_pulses - rd0);
    end
  endtask

  task automatic test_single_press();
    int wr0, rd0, hi0, lat;
    wr0 = wr_pulses; rd0 = rd_pulses; hi0 = wr_hi; lat = 0;
    key_in_wr = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (key_wr && lat == 0) lat = k;
    end
    key_in_wr = 1'b1;
    step(30);
    tests_run++;
    if (lat < 11 || lat > 13) begin
      tests_failed++;
      $display("FAIL press_latency: got %0d expected 11..13", lat);
    end
    tests_run++;
    if ((wr_pulses - wr0) !== 1) begin
      tests_failed++;
      $display("FAIL press_count: got %0d expected 1", wr_pulses - wr0);
    end
    tests_run++;
    if ((wr_hi - hi0) !== 1) begin
      tests_failed++;
      $display("FAIL press_width: got %0d expected 1", wr_hi - hi0);
    end
    tests_run++;
    if ((rd_pulses - rd0) !== 0) begin
      tests_failed++;
      $display("FAIL press_rd_quiet: got %0d expected 0", rd_pulses - rd0);
    end
  endtask

  task automatic test_bounce_reject();
    int wr0, rd0;
    wr0 = wr_pulses; rd0 = rd_pulses;
    for (int i = 0; i < 10; i++) begin
      key_in_rd = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(4);
    end
    key_in_rd = 1'b1;
    step(30);
    tests_run++;
    if ((rd_pulses - rd0) !== 0 || (wr_pulses - wr0) !== 0) begin
      tests_failed++;
      $display("FAIL bounce_reject: got rd=%0d wr=%0d expected 0 0", rd_pulses - rd0, wr_pulses - wr0);
    end
  endtask

  task automatic test_same_cycle();
    int wr0, rd0, wr_k, rd_k, both0;
    wr0 = wr_pulses; rd0 = rd_pulses; both0 = both_hi;
    wr_k = 0; rd_k = 0;
    key_in_wr = 1'b0;
    key_in_rd = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step(1);
      if (key_wr && wr_k == 0) wr_k = k;
      if (key_rd && rd_k == 0) rd_k = k;
    end
    key_in_wr = 1'b1;
    key_in_rd = 1'b1;
    step(30);
    tests_run++;
    if (wr_k == 0 || rd_k !== wr_k + 1) begin
      tests_failed++;
      $display("FAIL same_cycle_order: got wr@%0d rd@%0d expected rd one clk after wr", wr_k, rd_k);
    end
    tests_run++;
    if ((wr_pulses - wr0) !== 1 || (rd_pulses - rd0) !== 1) begin
      tests_failed++;
      $display("FAIL same_cycle_count: got wr=%0d rd=%0d expected 1 1", wr_pulses - wr0, rd_pulses - rd0);
    end
    tests_run++;
    if ((both_hi - both0) !== 0) begin
      tests_failed++;
      $display("FAIL same_cycle_overlap: got %0d expected 0", both_hi - both0);
    end
  endtask

  task automatic test_release_glitch();
    int wr0;
    wr0 = wr_pulses;
    key_in_wr = 1'b0; step(20);
    key_in_wr = 1'b1; step(3);
    key_in_wr = 1'b0; step(3);
    key_in_wr = 1'b1; step(3);
    key_in_wr = 1'b0; step(3);
    key_in_wr = 1'b1; step(30);
    key_in_wr = 1'b0; step(30);
    key_in_wr = 1'b1; step(30);
    tests_run++;
    if ((wr_pulses - wr0) !== 2) begin
      tests_failed++;
      $display("FAIL release_glitch: got %0d expected 2", wr_pulses - wr0);
    end
  endtask

  task automatic test_reset_in_filter();
    int wr0, first_k;
    logic rst_bad;
    wr0 = wr_pulses; first_k = 0; rst_bad = 1'b0;
    key_in_wr = 1'b0;
    step(11);
    rst_n = 1'b0;
    #1;
    if (key_wr !== 1'b0 || key_rd !== 1'b0) rst_bad = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(1);
      if (key_wr !== 1'b0 || key_rd !== 1'b0) rst_bad = 1'b1;
    end
    tests_run++;
    if (rst_bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs_low: got nonzero output during reset expected 0");
    end
    tests_run++;
    if ((wr_pulses - wr0) !== 0) begin
      tests_failed++;
      $display("FAIL reset_discard: got %0d pulses before release expected 0", wr_pulses - wr0);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (key_wr && first_k == 0) first_k = k;
    end
    tests_run++;
    if (first_k < 12 || first_k > 14) begin
      tests_failed++;
      $display("FAIL reset_refilter: got pulse at %0d expected 12..14 (0 = timeout)", first_k);
    end
    key_in_wr = 1'b1;
    step(30);
    tests_run++;
    if ((wr_pulses - wr0) !== 1) begin
      tests_failed++;
      $display("FAIL reset_refilter_count: got %0d expected 1", wr_pulses - wr0);
    end
  endtask

  task automatic test_long_hold();
    int rd0, rd_hi0;
    rd0 = rd_pulses; rd_hi0 = rd_hi;
    key_in_rd = 1'b0;
    step(1000);
    key_in_rd = 1'b1;
    step(30);
    tests_run++;
    if ((rd_pulses - rd0) !== 1 || (rd_hi - rd_hi0) !== 1) begin
      tests_failed++;
      $display("FAIL long_hold: got pulses=%0d high_cycles=%0d expected 1 1", rd_pulses - rd0, rd_hi - rd_hi0);
    end
    tests_run++;
    if (both_hi !== 0) begin
      tests_failed++;
      $display("FAIL never_overlap: got %0d expected 0", both_hi);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce_reject();
    test_same_cycle();
    test_release_glitch();
    test_reset_in_filter();
    test_long_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter CNT_MAX, default 999_999: filter count; 20 ms at 50 MHz.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth per key.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 key_in_wr  input  1  raw write push-button; asynchronous to clk; active-low, 0 = pressed.
REQ-006 key_in_rd  input  1  raw read push-button; asynchronous to clk; active-low, 0 = pressed.
REQ-007 key_wr  output  1  one-clk pulse per debounced write-key press; drives the I2C command FSM.
REQ-008 key_rd  output  1  one-clk pulse per debounced read-key press; drives the I2C command FSM.

Function
REQ-009 Each key SHALL pass through a SYNC_STAGES flop synchronizer before any other logic; reset value 1 (released).
REQ-010 Each channel SHALL run a 4-state FSM: IDLE, PRESS_FILT, DOWN, REL_FILT.
REQ-011 IDLE: synced key = 0 -> PRESS_FILT, counter cleared to 0.
REQ-012 PRESS_FILT: counter increments while synced key = 0; synced key = 1 -> IDLE, counter cleared (bounce rejected).
REQ-013 PRESS_FILT: counter == CNT_MAX with key still 0 -> DOWN; exactly one press event raised on that transition.
REQ-014 DOWN: synced key = 1 -> REL_FILT, counter cleared; holding the key indefinitely SHALL raise no further events.
REQ-015 REL_FILT: counter increments while key = 1; key = 0 -> DOWN, counter cleared; counter == CNT_MAX -> IDLE.
REQ-016 Counter width SHALL be $clog2(CNT_MAX+1); counter SHALL saturate, never wrap, and clear on every state change.
REQ-017 Latency: press event SHALL be asserted SYNC_STAGES + CNT_MAX + 2 clk after the first stable-low sample at the raw pin (+/-1 clk for metastability).
REQ-018 key_wr and key_rd SHALL be registered outputs, high for exactly one clk per event.
REQ-019 key_wr and key_rd SHALL never be high in the same clk.
REQ-020 Same-cycle events: key_wr SHALL fire first; the rd event is held in a 1-bit pending flag and key_rd fires the following clk.
REQ-021 A pending rd SHALL not be lost or duplicated if a new wr event arrives while it is pending; pending rd wins that clk and wr is deferred one clk symmetrically.
REQ-022 The two channels SHALL be fully independent apart from the REQ-019 to REQ-021 arbitration.

Reset
REQ-023 rst_n low SHALL asynchronously force: both FSMs to IDLE, counters to 0, synchronizers to 1, pending flags to 0, key_wr = 0, key_rd = 0.
REQ-024 Reset during PRESS_FILT or DOWN SHALL discard the event; after release a still-held key SHALL need a full CNT_MAX filter before pulsing.
REQ-025 Reset deassertion SHALL be used directly, without an internal reset synchronizer; the integrating top supplies a synchronized deassert.

Structure
REQ-026 FSM state encoding (4 states, 2 bits) and the default CNT_MAX SHALL live in a shared key package for reuse by other button blocks.
REQ-027 One channel sub-module key_debounce_ch (synchronizer, counter, FSM, press-event output) SHALL be instantiated twice.
REQ-028 Arbitration and output registers SHALL live in key_debounce.

Verification (CNT_MAX = 9, SYNC_STAGES = 2)
REQ-029 key_in_wr low, held 100 clk -> single key_wr pulse, width 1, at 12 +/- 1 clk after the fall; key_rd stays 0.
REQ-030 key_in_rd toggled every 4 clk for 40 clk, then high -> no key_rd pulse.
REQ-031 Both keys fall in the same clk and are held -> key_wr at cycle N, key_rd at N+1; exactly one pulse each.
REQ-032 Key pressed, released with 3-clk bounce glitches, re-pressed after 30 clk -> exactly two pulses, no pulse from the glitches.
REQ-033 rst_n low at clk 8 of PRESS_FILT, high at 10, key held -> no pulse before 12 clk after reset release; all outputs 0 during reset.
REQ-034 Key held for 1000 clk -> exactly one pulse.
